// File: rtl/pll_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reconfig_ctrl
//
// Supervisor and dynamic-reconfiguration controller for a Gowin PLLVR with
// dynamic IDIV/FBDIV/ODIV selection enabled. Runs on the PLL reference clock.
// Pulses the PLL reset, waits for LOCK with a timeout and bounded retries,
// qualifies LOCK over a run of consecutive samples, and then releases a reset
// for logic in the PLL output domain. New divider settings are accepted
// through a valid/ready handshake while running or after a lock failure.
//
// Ports:
//   clkin         in   reference clock (same net as PLL CLKIN)
//   rst_n         in   asynchronous active-low reset
//   cfg_valid     in   new configuration request (held by the requester)
//   cfg_ready     out  configuration accepted when cfg_valid & cfg_ready
//   cfg_idiv      in   IDIV_SEL value
//   cfg_fbdiv     in   FBDIV_SEL value
//   cfg_odsel     in   raw ODSEL code
//   pll_lock      in   PLL LOCK (asynchronous to clkin)
//   pll_reset     out  PLL RESET
//   pll_idsel     out  PLL IDSEL (inverted IDIV_SEL)
//   pll_fbdsel    out  PLL FBDSEL (inverted FBDIV_SEL)
//   pll_odsel     out  PLL ODSEL (raw code)
//   locked        out  qualified lock
//   user_rst_n    out  active-low reset for the clkout domain
//   busy          out  reset / lock / settle sequencing in progress
//   err           out  sticky lock failure
//   lock_loss_cnt out  saturating count of lock drops while running
// ---------------------------------------------------------------------------
module pll_reconfig_ctrl #(
    parameter int         DEF_IDIV      = 8,
    parameter int         DEF_FBDIV     = 25,
    parameter logic [5:0] DEF_ODSEL     = 6'd60,
    parameter int         RST_CYCLES    = 16,
    parameter int         LOCK_TIMEOUT  = 65535,
    parameter int         SETTLE_CYCLES = 1024,
    parameter int         MAX_RETRY     = 3,
    parameter int         CNT_W         = 8
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [5:0]       cfg_idiv,
    input  logic [5:0]       cfg_fbdiv,
    input  logic [5:0]       cfg_odsel,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic [5:0]       pll_idsel,
    output logic [5:0]       pll_fbdsel,
    output logic [5:0]       pll_odsel,
    output logic             locked,
    output logic             user_rst_n,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    // The PLL select pins take the bitwise inverse of the divider value.
    localparam logic [5:0] DEF_IDSEL  = ~6'(DEF_IDIV);
    localparam logic [5:0] DEF_FBDSEL = ~6'(DEF_FBDIV);

    // One timer serves both the reset pulse and the lock timeout.
    localparam int TMR_MAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 1);

    localparam logic [TMR_W-1:0] RST_LAST   = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(LOCK_TIMEOUT - 1);
    localparam int               SET_LAST_I = (SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 1;
    localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SET_LAST_I);
    localparam logic [RTY_W-1:0] RTY_LIMIT  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RST_PLL,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [SET_W-1:0] settle_cnt;
    logic [RTY_W-1:0] retry_cnt;
    logic [RTY_W-1:0] retry_nxt;
    logic             lock_meta;
    logic             lock_s;
    logic             cfg_accept;
    logic             settle_done;

    // Two-flop synchroniser for the asynchronous LOCK pin.
    // NOTE: sequential state is updated only with non-blocking (<=)
    // assignments so every flop samples pre-edge values and the order of
    // statements inside the block cannot change the hardware.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // cfg_ready is a registered decode of RUN/FAIL, so this is only true there.
    assign cfg_accept = cfg_valid && cfg_ready;
    assign retry_nxt  = retry_cnt + RTY_W'(1);

    // The sample that moves WAIT_LOCK into SETTLE counts as the first settle
    // sample, so with a single-sample window that sample already qualifies.
    assign settle_done = lock_s &&
                         (((state == ST_WAIT_LOCK) && (SETTLE_CYCLES == 1)) ||
                          ((state == ST_SETTLE) && (settle_cnt == SET_LAST)));

    // Main sequencer. Every output is registered and updated on the same
    // edge as the state change that implies it.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RST_PLL;
            timer      <= '0;
            settle_cnt <= '0;
            retry_cnt  <= '0;
            pll_reset  <= 1'b1;
            pll_idsel  <= DEF_IDSEL;
            pll_fbdsel <= DEF_FBDSEL;
            pll_odsel  <= DEF_ODSEL;
            locked     <= 1'b0;
            user_rst_n <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
            cfg_ready  <= 1'b0;
        end else if (cfg_accept) begin
            // New selects land on the same edge that raises pll_reset.
            state      <= ST_RST_PLL;
            timer      <= '0;
            retry_cnt  <= '0;
            pll_reset  <= 1'b1;
            pll_idsel  <= ~cfg_idiv;
            pll_fbdsel <= ~cfg_fbdiv;
            pll_odsel  <= cfg_odsel;
            locked     <= 1'b0;
            user_rst_n <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
            cfg_ready  <= 1'b0;
        end else if (settle_done) begin
            state      <= ST_RUN;
            retry_cnt  <= '0;
            locked     <= 1'b1;
            user_rst_n <= 1'b1;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
        end else begin
            case (state)
                ST_RST_PLL: begin
                    if (timer == RST_LAST) begin
                        state     <= ST_WAIT_LOCK;
                        timer     <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SET_W'(1);
                    end else if (timer == TO_LAST) begin
                        retry_cnt <= retry_nxt;
                        if (retry_nxt == RTY_LIMIT) begin
                            state     <= ST_FAIL;
                            err       <= 1'b1;
                            busy      <= 1'b0;
                            cfg_ready <= 1'b1;
                        end else begin
                            state     <= ST_RST_PLL;
                            timer     <= '0;
                            pll_reset <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                ST_SETTLE: begin
                    // A dropout restarts qualification but keeps the timeout
                    // running, so a chattering LOCK still times out.
                    if (!lock_s) begin
                        state <= ST_WAIT_LOCK;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end

                ST_RUN: begin
                    if (!lock_s) begin
                        state      <= ST_RST_PLL;
                        timer      <= '0;
                        pll_reset  <= 1'b1;
                        locked     <= 1'b0;
                        user_rst_n <= 1'b0;
                        busy       <= 1'b1;
                        cfg_ready  <= 1'b0;
                    end
                end

                default: begin
                    // ST_FAIL: hold until a configuration is accepted.
                end
            endcase
        end
    end

    // Lock drops in RUN are counted even when a cfg accept wins the edge.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt <= '0;
        end else if ((state == ST_RUN) && !lock_s && (lock_loss_cnt != '1)) begin
            lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_reconfig_ctrl
//
// Directed bench for pll_reconfig_ctrl with short timing parameters
// (RST_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=16, MAX_RETRY=3).
// Cycle c is the interval between posedge c and posedge c+1, with rst_n
// released just after posedge 0. Inputs change 1 time unit after a posedge;
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pll_reconfig_ctrl;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [5:0] cfg_idiv = '0;
    logic [5:0] cfg_fbdiv = '0;
    logic [5:0] cfg_odsel = '0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       locked;
    logic       user_rst_n;
    logic       busy;
    logic       err;
    logic [7:0] lock_loss_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clkin = ~clkin;

    pll_reconfig_ctrl #(
        .DEF_IDIV      (8),
        .DEF_FBDIV     (25),
        .DEF_ODSEL     (6'd60),
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (100),
        .SETTLE_CYCLES (16),
        .MAX_RETRY     (3),
        .CNT_W         (8)
    ) dut (
        .clkin         (clkin),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_idiv      (cfg_idiv),
        .cfg_fbdiv     (cfg_fbdiv),
        .cfg_odsel     (cfg_odsel),
        .pll_lock      (pll_lock),
        .pll_reset     (pll_reset),
        .pll_idsel     (pll_idsel),
        .pll_fbdsel    (pll_fbdsel),
        .pll_odsel     (pll_odsel),
        .locked        (locked),
        .user_rst_n    (user_rst_n),
        .busy          (busy),
        .err           (err),
        .lock_loss_cnt (lock_loss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic mid();
        @(negedge clkin);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " pll_reset"},     pll_reset,     1);
        check({tag, " locked"},        locked,        0);
        check({tag, " user_rst_n"},    user_rst_n,    0);
        check({tag, " busy"},          busy,          1);
        check({tag, " err"},           err,           0);
        check({tag, " cfg_ready"},     cfg_ready,     0);
        check({tag, " lock_loss_cnt"}, lock_loss_cnt, 0);
        check({tag, " idsel"},         pll_idsel,     55);
        check({tag, " fbdsel"},        pll_fbdsel,    38);
        check({tag, " odsel"},         pll_odsel,     60);
    endtask

    // Leaves the bench at cycle 0 (just after the first posedge with rst_n high).
    task automatic do_reset();
        rst_n     = 1'b0;
        pll_lock  = 1'b0;
        cfg_valid = 1'b0;
        repeat (2) @(posedge clkin);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values while rst_n is low.
        #12;
        check_reset_vals("por");

        // Power-up: lock rises at cycle 10, locked expected at 10+2+16 = 28.
        do_reset();
        for (int c = 0; c <= 35; c++) begin
            pll_lock = (c >= 10);
            mid();
            check($sformatf("pu pll_reset c%0d", c),  pll_reset,  c < 4);
            check($sformatf("pu locked c%0d", c),     locked,     c >= 28);
            check($sformatf("pu user_rst_n c%0d", c), user_rst_n, c >= 28);
            check($sformatf("pu busy c%0d", c),       busy,       c < 28);
            step();
        end
        check("pu idsel",     pll_idsel,  55);
        check("pu fbdsel",    pll_fbdsel, 38);
        check("pu odsel",     pll_odsel,  60);
        check("pu cfg_ready", cfg_ready,  1);

        // Glitchy lock: high 10..17, low 18, high from 19 -> locked at 37.
        // cfg_valid held while busy must be ignored.
        do_reset();
        cfg_idiv  = 6'd1;
        cfg_fbdiv = 6'd1;
        cfg_odsel = 6'd1;
        for (int c = 0; c <= 45; c++) begin
            pll_lock  = ((c >= 10) && (c < 18)) || (c >= 19);
            cfg_valid = (c < 30);
            mid();
            check($sformatf("glitch locked c%0d", c), locked, c >= 37);
            step();
        end
        check("glitch lock_loss_cnt", lock_loss_cnt, 0);
        check("glitch idsel kept",    pll_idsel,     55);
        check("glitch fbdsel kept",   pll_fbdsel,    38);
        check("glitch odsel kept",    pll_odsel,     60);

        // Timeout: three 4-cycle reset pulses 104 apart, FAIL from cycle 312,
        // then a cfg at 320 is accepted from FAIL.
        do_reset();
        for (int c = 0; c <= 321; c++) begin
            pll_lock  = 1'b0;
            cfg_valid = (c == 320);
            if (c == 320) begin
                cfg_idiv  = 6'd3;
                cfg_fbdiv = 6'd9;
                cfg_odsel = 6'd5;
            end
            mid();
            check($sformatf("to pll_reset c%0d", c), pll_reset,
                  (((c % 104) < 4) && (c < 312)) || (c == 321));
            check($sformatf("to err c%0d", c),       err,       (c >= 312) && (c < 321));
            check($sformatf("to busy c%0d", c),      busy,      (c < 312) || (c == 321));
            check($sformatf("to cfg_ready c%0d", c), cfg_ready, (c >= 312) && (c < 321));
            if (c == 321) begin
                check("fail-cfg idsel",  pll_idsel,  60);
                check("fail-cfg fbdsel", pll_fbdsel, 54);
                check("fail-cfg odsel",  pll_odsel,  5);
            end
            step();
        end
        cfg_valid = 1'b0;

        // Reconfig in RUN at cycle 30 (accepted on edge 31). PLL loses lock
        // while reset and relocks at 41 -> locked again at 31+28 = 59.
        do_reset();
        cfg_idiv  = 6'd2;
        cfg_fbdiv = 6'd12;
        cfg_odsel = 6'd56;
        for (int c = 0; c <= 62; c++) begin
            pll_lock  = ((c >= 10) && (c < 31)) || (c >= 41);
            cfg_valid = (c == 30);
            mid();
            check($sformatf("rc locked c%0d", c),    locked,    ((c >= 28) && (c < 31)) || (c >= 59));
            check($sformatf("rc pll_reset c%0d", c), pll_reset, (c < 4) || ((c >= 31) && (c < 35)));
            if (c == 30) begin
                check("rc idsel before", pll_idsel, 55);
            end
            if (c == 31) begin
                check("rc idsel",      pll_idsel,  61);
                check("rc fbdsel",     pll_fbdsel, 51);
                check("rc odsel",      pll_odsel,  56);
                check("rc user_rst_n", user_rst_n, 0);
                check("rc cfg_ready",  cfg_ready,  0);
            end
            step();
        end
        check("rc lock_loss_cnt", lock_loss_cnt, 0);

        // Lock loss 300 times: locked falls 3 cycles after pll_lock falls,
        // relock 20 cycles after that; the counter saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            pll_lock = 1'b0;
            step();
            step();
            mid();
            check($sformatf("ll%0d locked d+2", i), locked, 1);
            step();
            pll_lock = 1'b1;
            mid();
            check($sformatf("ll%0d locked d+3", i), locked, 0);
            check($sformatf("ll%0d count", i), lock_loss_cnt, (i > 255) ? 255 : i);
            repeat (19) step();
            mid();
            check($sformatf("ll%0d locked d+22", i), locked, 0);
            step();
            mid();
            check($sformatf("ll%0d locked d+23", i), locked, 1);
            step();
        end

        // Async reset mid-SETTLE: outputs and the reconfigured selects revert
        // before any clock edge.
        pll_lock = 1'b0;
        repeat (3) step();
        pll_lock = 1'b1;
        repeat (7) step();
        mid();
        check("settle busy",  busy,      1);
        check("settle idsel", pll_idsel, 61);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        pll_lock = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Supervisor and dynamic-reconfiguration controller for a Gowin PLLVR instance with DYN_IDIV_SEL/DYN_FBDIV_SEL/DYN_ODIV_SEL enabled.
- Runs on the PLL reference clock. Drives the PLL's IDSEL/FBDSEL/ODSEL and RESET pins.
- Qualifies LOCK with a debounce window and retries with a timeout. Produces a clean locked flag and a reset for the PLL output domain.
- Generalises the fixed 27 MHz -> 78 MHz configuration to run-time divider selection.

Parameters:
- DEF_IDIV, 8, power-up IDIV_SEL value (0..63)
- DEF_FBDIV, 25, power-up FBDIV_SEL value (0..63)
- DEF_ODSEL, 6'd60, power-up raw ODSEL code (ODIV=8)
- RST_CYCLES, 16, clkin cycles pll_reset is held high per attempt (>=1)
- LOCK_TIMEOUT, 65535, cycles to wait for synced lock per attempt (>=2)
- SETTLE_CYCLES, 1024, consecutive synced-high lock samples required (>=1)
- MAX_RETRY, 3, lock attempts before FAIL (>=1)
- CNT_W, 8, width of lock_loss_cnt

Ports:
- clkin  in  1  reference clock (same net as PLL CLKIN)
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  new configuration request
- cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready
- cfg_idiv  in  6  IDIV_SEL value
- cfg_fbdiv  in  6  FBDIV_SEL value
- cfg_odsel  in  6  raw ODSEL code
- pll_lock  in  1  PLL LOCK (asynchronous)
- pll_reset  out  1  to PLL RESET
- pll_idsel  out  6  to PLL IDSEL
- pll_fbdsel  out  6  to PLL FBDSEL
- pll_odsel  out  6  to PLL ODSEL
- locked  out  1  qualified lock
- user_rst_n  out  1  reset for logic clocked by clkout
- busy  out  1  sequencing in progress
- err  out  1  sticky lock failure
- lock_loss_cnt  out  CNT_W  saturating count of lock drops in RUN

Behaviour:
- Reset values while rst_n=0:
  - pll_reset=1, locked=0, user_rst_n=0, busy=1, err=0, cfg_ready=0, lock_loss_cnt=0.
  - pll_idsel=~DEF_IDIV, pll_fbdsel=~DEF_FBDIV, pll_odsel=DEF_ODSEL.
  - State=RST_PLL; all timers and retry_cnt are 0.
- Divider encoding: pll_idsel/pll_fbdsel are the bitwise inverse of the divider value. pll_odsel passes through unchanged. All three are registered and change only on an accepted cfg or on reset.
- pll_lock passes through a 2-flop synchroniser to give lock_s. This adds 2 cycles of latency.
- user_rst_n asserts asynchronously with rst_n and otherwise equals registered locked.
- busy=1 in RST_PLL, WAIT_LOCK and SETTLE. cfg_ready=1 only in RUN and FAIL.
- RST_PLL:
  - pll_reset=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with timer=0.
- WAIT_LOCK:
  - pll_reset=0.
  - If lock_s=1, go to SETTLE with settle count=1.
  - Otherwise, when timer reaches LOCK_TIMEOUT-1, increment retry_cnt. If the new retry_cnt equals MAX_RETRY, go to FAIL and set err=1; otherwise go to RST_PLL.
- SETTLE:
  - Count consecutive lock_s=1 cycles. Any lock_s=0 returns to WAIT_LOCK; the timer is not reset.
  - When the count reaches SETTLE_CYCLES, go to RUN: locked=1 and retry_cnt=0.
  - Latency from pll_lock rising to locked=1 is 2+SETTLE_CYCLES cycles, provided the lock stays stable.
- RUN:
  - If lock_s falls: locked=0 on the next edge, lock_loss_cnt increments (saturating at all-ones), go to RST_PLL.
- FAIL:
  - pll_reset=0, locked=0, err held. Exits only on an accepted cfg or rst_n.
- cfg handshake (RUN or FAIL, cfg_valid=1):
  - Latch the cfg_* fields into the select registers.
  - Clear err and retry_cnt; locked=0; cfg_ready drops the next cycle; go to RST_PLL.
  - Select outputs change in the same edge that pll_reset rises.
- Simultaneous cfg accept and lock loss in RUN: cfg wins (new selects latched), and lock_loss_cnt still increments.
- cfg_valid outside RUN/FAIL is ignored. There is no queuing, and the requester must hold cfg_valid.
- rst_n asserted mid-sequence aborts immediately to reset values. Defaults are reloaded, so the last cfg is lost.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=100, SETTLE_CYCLES=16, MAX_RETRY=3):
- Power-up:
  - Stimulus: release rst_n; pll_lock rises at cycle 10 and stays high.
  - Required: pll_reset=1 for cycles 0-3; pll_idsel=55, pll_fbdsel=38, pll_odsel=60; locked and user_rst_n rise at cycle 28; busy=0.
- Glitchy lock:
  - Stimulus: pll_lock high for 8 cycles, low for 1, then stable.
  - Required: settle restarts, locked rises 18 cycles after the final rise, lock_loss_cnt=0.
- Timeout:
  - Stimulus: pll_lock stuck at 0.
  - Required: 3 pll_reset pulses of 4 cycles spaced 104 cycles apart; err=1, busy=0, cfg_ready=1 after the third timeout.
- Reconfig:
  - Stimulus: in RUN, cfg_valid with idiv=2, fbdiv=12, odsel=56.
  - Required: next cycle pll_idsel=61, pll_fbdsel=51, pll_odsel=56, pll_reset=1, locked=0, user_rst_n=0; relock follows the same timing as power-up.
- Lock loss:
  - Stimulus: drop pll_lock in RUN 300 times.
  - Required: each drop gives locked=0 3 cycles after pll_lock falls; lock_loss_cnt saturates at 255.
- Async reset mid-SETTLE:
  - Stimulus: assert rst_n low during SETTLE.
  - Required: all outputs take reset values immediately, with no clock edge needed.
